// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_t : fetch FSM states
//   fetch_pkt_t   : fetched instruction word paired with its PC + 4
//   NOP_ENC       : default bubble instruction encoding
//   PC_INC        : sequential PC increment
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc_inc;
  } fetch_pkt_t;

  localparam logic [31:0] NOP_ENC = 32'h0000_0000;
  localparam logic [31:0] PC_INC  = 32'd4;

endpackage

// File: rtl/if_fetch_unit_hold_buf.sv
// if_hold_buf: one-entry buffer that parks a fetched instruction while the
// IF/ID register is stalled.
//   clk, rst_b : clock, synchronous active-high reset
//   load       : capture data_in and mark the entry valid
//   clear      : invalidate the entry (wins over load)
//   data_in    : instruction word + PC + 4 to park
//   data_out   : parked instruction word + PC + 4
//   valid      : entry holds a fetched instruction
module if_hold_buf
  import if_fetch_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst_b,
  input  logic       load,
  input  logic       clear,
  input  fetch_pkt_t data_in,
  output fetch_pkt_t data_out,
  output logic       valid
);

  always_ff @(posedge clk) begin
    if (rst_b) begin
      valid    <= 1'b0;
      data_out <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid    <= 1'b1;
      data_out <= data_in;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage with a single outstanding memory
// request, stall hold buffer and redirect flush.
//   clk, rst_b          : clock, synchronous active-high reset
//   stall               : IF/ID not accepting; IF outputs hold
//   redirect_valid/_pc  : taken branch/jump; flush IF and refetch from target
//   imem_req/_addr      : instruction memory request and word address
//   imem_rvalid/_rdata  : memory response completing the outstanding request
//   pc_incremented_IF   : PC + 4 of the instruction in inst_IF
//   inst_IF             : fetched instruction, or NOP_INST for a bubble
//   inst_valid_IF       : inst_IF is a real instruction
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_ENC
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_incremented_IF,
  output logic [31:0] inst_IF,
  output logic        inst_valid_IF
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  discard_addr;  // address of the request being drained in DISCARD
  logic         accept;
  logic         hold_load;
  logic         hold_clear;
  logic         hold_valid;
  fetch_pkt_t   hold_q;

  assign imem_req  = !rst_b && (state != HOLD);
  // DISCARD keeps presenting the abandoned address so the bus request stays stable
  assign imem_addr = (state == DISCARD) ? discard_addr : pc;
  assign accept    = imem_req && imem_rvalid;

  assign hold_load  = accept && (state == FETCH) && stall && !redirect_valid;
  assign hold_clear = redirect_valid || ((state == HOLD) && !stall);

  if_hold_buf u_hold_buf (
    .clk      (clk),
    .rst_b    (rst_b),
    .load     (hold_load),
    .clear    (hold_clear),
    .data_in  ('{inst: imem_rdata, pc_inc: pc + PC_INC}),
    .data_out (hold_q),
    .valid    (hold_valid)
  );

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state             <= FETCH;
      pc                <= RESET_PC;
      discard_addr      <= RESET_PC;
      inst_IF           <= NOP_INST;
      pc_incremented_IF <= '0;
      inst_valid_IF     <= 1'b0;
    end else if (redirect_valid) begin
      pc            <= redirect_pc;
      inst_IF       <= NOP_INST;
      inst_valid_IF <= 1'b0;
      unique case (state)
        FETCH: begin
          if (!accept) begin
            state        <= DISCARD;
            discard_addr <= pc;
          end
        end
        HOLD:    state <= FETCH;
        DISCARD: if (accept) state <= FETCH;
        default: state <= FETCH;
      endcase
    end else begin
      unique case (state)
        FETCH: begin
          if (accept) begin
            pc <= pc + PC_INC;
            if (stall) begin
              state <= HOLD;
            end else begin
              inst_IF           <= imem_rdata;
              pc_incremented_IF <= pc + PC_INC;
              inst_valid_IF     <= 1'b1;
            end
          end else if (!stall) begin
            inst_IF       <= NOP_INST;
            inst_valid_IF <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            state <= FETCH;
            if (hold_valid) begin
              inst_IF           <= hold_q.inst;
              pc_incremented_IF <= hold_q.pc_inc;
              inst_valid_IF     <= 1'b1;
            end else begin
              inst_IF       <= NOP_INST;
              inst_valid_IF <= 1'b0;
            end
          end
        end
        DISCARD: begin
          if (accept) state <= FETCH;
          if (!stall) begin
            inst_IF       <= NOP_INST;
            inst_valid_IF <= 1'b0;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: directed vector table, a wrap-around reset
// instance, and a randomized run checked against an instruction-stream model.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        rst_b, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_rvalid, inst_valid_IF;
  logic [31:0] imem_addr, imem_rdata, pc_incremented_IF, inst_IF;

  logic        stall2, redirect_valid2, imem_req2, imem_rvalid2, inst_valid2;
  logic [31:0] redirect_pc2, imem_addr2, imem_rdata2, pci2, inst2;

  int tests = 0;
  int fails = 0;

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_b(rst_b), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc_incremented_IF(pc_incremented_IF), .inst_IF(inst_IF),
    .inst_valid_IF(inst_valid_IF)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(NOP)) dut2 (
    .clk(clk), .rst_b(rst_b), .stall(stall2), .redirect_valid(redirect_valid2),
    .redirect_pc(redirect_pc2), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
    .pc_incremented_IF(pci2), .inst_IF(inst2), .inst_valid_IF(inst_valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h5EED_0000) + 32'h0101_0101;
  endfunction

  typedef struct {
    logic        rst, stl, rdr;
    logic [31:0] rpc;
    logic        rv;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epci, einst;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, stl, rdr, input logic [31:0] rpc,
                              input logic rv, ereq, input logic [31:0] eaddr,
                              input logic evalid, input logic [31:0] epci, einst);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rdr = rdr; v.rpc = rpc; v.rv = rv;
    v.ereq = ereq; v.eaddr = eaddr; v.evalid = evalid; v.epci = epci; v.einst = einst;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Second instance: always-ready zero-latency memory, no stall, no redirect.
  initial begin
    stall2 = 1'b0; redirect_valid2 = 1'b0; redirect_pc2 = '0;
    imem_rvalid2 = 1'b0; imem_rdata2 = '0;
    forever begin
      @(negedge clk);
      #1;
      imem_rvalid2 = imem_req2;
      imem_rdata2  = mem_word(imem_addr2);
    end
  end

  logic [31:0] exp_pc, rpc, prev_addr;
  logic        prev_req, prev_rv, prev_rst, new_rst, new_stall, new_redir, busy, got;
  int unsigned wait_cnt;
  int          idle, delivered;

  initial begin
    rst_b = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;

    // rst stall rdr rpc rv | req addr valid pci inst
    vecs.push_back(mk(1,0,0,32'h0,  0, 0,32'h0,  0,32'h0,  NOP));
    vecs.push_back(mk(0,0,0,32'h0,  1, 1,32'h4,  1,32'h4,  mem_word(32'h0)));
    vecs.push_back(mk(0,0,0,32'h0,  1, 1,32'h8,  1,32'h8,  mem_word(32'h4)));
    vecs.push_back(mk(0,1,0,32'h0,  1, 0,32'hC,  1,32'h8,  mem_word(32'h4)));
    vecs.push_back(mk(0,1,0,32'h0,  0, 0,32'hC,  1,32'h8,  mem_word(32'h4)));
    vecs.push_back(mk(0,1,0,32'h0,  0, 0,32'hC,  1,32'h8,  mem_word(32'h4)));
    vecs.push_back(mk(0,0,0,32'h0,  0, 1,32'hC,  1,32'hC,  mem_word(32'h8)));
    vecs.push_back(mk(0,0,0,32'h0,  0, 1,32'hC,  0,32'hC,  NOP));
    vecs.push_back(mk(0,0,0,32'h0,  1, 1,32'h10, 1,32'h10, mem_word(32'hC)));
    vecs.push_back(mk(0,0,0,32'h0,  0, 1,32'h10, 0,32'h10, NOP));
    vecs.push_back(mk(0,0,1,32'h100,0, 1,32'h10, 0,32'h10, NOP));
    vecs.push_back(mk(0,0,0,32'h0,  1, 1,32'h100,0,32'h10, NOP));
    vecs.push_back(mk(0,0,0,32'h0,  0, 1,32'h100,0,32'h10, NOP));
    vecs.push_back(mk(0,0,0,32'h0,  1, 1,32'h104,1,32'h104,mem_word(32'h100)));
    vecs.push_back(mk(0,1,1,32'h200,1, 1,32'h200,0,32'h104,NOP));
    vecs.push_back(mk(0,0,0,32'h0,  1, 1,32'h204,1,32'h204,mem_word(32'h200)));
    vecs.push_back(mk(0,0,0,32'h0,  1, 1,32'h208,1,32'h208,mem_word(32'h204)));
    vecs.push_back(mk(0,0,0,32'h0,  1, 1,32'h20C,1,32'h20C,mem_word(32'h208)));
    vecs.push_back(mk(0,1,0,32'h0,  1, 0,32'h210,1,32'h20C,mem_word(32'h208)));
    vecs.push_back(mk(1,1,1,32'h300,1, 0,32'h0,  0,32'h0,  NOP));
    vecs.push_back(mk(0,0,0,32'h0,  0, 1,32'h0,  0,32'h0,  NOP));
    vecs.push_back(mk(0,0,0,32'h0,  1, 1,32'h4,  1,32'h4,  mem_word(32'h0)));
    vecs.push_back(mk(0,0,0,32'h0,  0, 1,32'h4,  0,32'h4,  NOP));
    vecs.push_back(mk(0,0,1,32'h400,0, 1,32'h4,  0,32'h4,  NOP));
    vecs.push_back(mk(0,0,1,32'h500,0, 1,32'h4,  0,32'h4,  NOP));
    vecs.push_back(mk(0,0,0,32'h0,  1, 1,32'h500,0,32'h4,  NOP));
    vecs.push_back(mk(0,0,0,32'h0,  1, 1,32'h504,1,32'h504,mem_word(32'h500)));
    vecs.push_back(mk(0,1,0,32'h0,  1, 0,32'h508,1,32'h504,mem_word(32'h500)));
    vecs.push_back(mk(0,1,1,32'h600,0, 1,32'h600,0,32'h504,NOP));
    vecs.push_back(mk(0,0,0,32'h0,  1, 1,32'h604,1,32'h604,mem_word(32'h600)));

    @(negedge clk);
    foreach (vecs[i]) begin
      rst_b = vecs[i].rst; stall = vecs[i].stl; redirect_valid = vecs[i].rdr;
      redirect_pc = vecs[i].rpc; imem_rvalid = vecs[i].rv;
      imem_rdata = mem_word(imem_addr);
      step();
      tests++;
      if (!(imem_req === vecs[i].ereq && (!vecs[i].ereq || imem_addr === vecs[i].eaddr) &&
            inst_valid_IF === vecs[i].evalid && pc_incremented_IF === vecs[i].epci &&
            inst_IF === vecs[i].einst)) begin
        fails++;
        $display("FAIL vec%0d: got req=%b addr=%h valid=%b pci=%h inst=%h, want req=%b addr=%h valid=%b pci=%h inst=%h",
                 i, imem_req, imem_addr, inst_valid_IF, pc_incremented_IF, inst_IF,
                 vecs[i].ereq, vecs[i].eaddr, vecs[i].evalid, vecs[i].epci, vecs[i].einst);
      end
    end

    // Wrap-around reset PC on the second instance.
    rst_b = 1'b1; stall = 1'b0; redirect_valid = 1'b0; imem_rvalid = 1'b0;
    step();
    tests++;
    if (imem_req2 !== 1'b0 || inst_valid2 !== 1'b0 || pci2 !== 32'h0) begin
      fails++;
      $display("FAIL wrap_reset: got req=%b valid=%b pci=%h, want req=0 valid=0 pci=00000000",
               imem_req2, inst_valid2, pci2);
    end
    rst_b = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      step();
      got = inst_valid2;
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL wrap_first: no valid output within 6 cycles, want one");
    end else if (pci2 !== 32'h0 || inst2 !== mem_word(32'hFFFF_FFFC)) begin
      fails++;
      $display("FAIL wrap_first: got pci=%h inst=%h, want pci=00000000 inst=%h",
               pci2, inst2, mem_word(32'hFFFF_FFFC));
    end
    tests++;
    if (imem_req2 !== 1'b1 || imem_addr2 !== 32'h0) begin
      fails++;
      $display("FAIL wrap_next_addr: got req=%b addr=%h, want req=1 addr=00000000",
               imem_req2, imem_addr2);
    end

    // Randomized run: delivered instructions must follow program order
    // (sequential from RESET_PC, jumping on redirect) with no loss or duplication.
    rst_b = 1'b1; stall = 1'b0; redirect_valid = 1'b0; imem_rvalid = 1'b0;
    step();
    exp_pc = 32'h0; busy = 1'b0; wait_cnt = 0; idle = 0; delivered = 0;
    prev_req = 1'b0; prev_rv = 1'b0; prev_rst = 1'b1; prev_addr = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      new_rst   = ($urandom_range(0, 299) == 0);
      new_stall = ($urandom_range(0, 2) == 0);
      new_redir = ($urandom_range(0, 11) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 + (32'($urandom_range(0, 7)) << 2))
                                         : (32'($urandom_range(0, 255)) << 2);
      if (new_rst) begin
        exp_pc = 32'h0;
        idle = 0;
      end else begin
        if (inst_valid_IF && !new_stall) begin
          tests++;
          if (pc_incremented_IF !== exp_pc + 32'd4 || inst_IF !== mem_word(exp_pc)) begin
            fails++;
            $display("FAIL stream@%0d: got pci=%h inst=%h, want pci=%h inst=%h",
                     cyc, pc_incremented_IF, inst_IF, exp_pc + 32'd4, mem_word(exp_pc));
          end
          exp_pc = exp_pc + 32'd4;
          delivered++;
          idle = 0;
        end else begin
          idle++;
        end
        if (new_redir) exp_pc = rpc;
      end
      rst_b = new_rst; stall = new_stall; redirect_valid = new_redir; redirect_pc = rpc;
      #1;
      if (prev_req && !prev_rv && !prev_rst && !rst_b) begin
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
          fails++;
          $display("FAIL req_stable@%0d: got req=%b addr=%h, want req=1 addr=%h",
                   cyc, imem_req, imem_addr, prev_addr);
        end
      end
      if (imem_req) begin
        if (!busy) begin
          busy = 1'b1;
          wait_cnt = $urandom_range(0, 2);
        end
        if (wait_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(imem_addr);
          busy = 1'b0;
        end else begin
          wait_cnt--;
          imem_rvalid = 1'b0;
        end
      end else begin
        imem_rvalid = 1'b0;
        busy = 1'b0;
      end
      prev_req = imem_req; prev_addr = imem_addr; prev_rv = imem_rvalid; prev_rst = rst_b;
      if (idle > 100) begin
        tests++;
        fails++;
        $display("FAIL progress@%0d: %0d cycles without a delivered instruction, want <= 100",
                 cyc, idle);
        break;
      end
      @(negedge clk);
    end
    tests++;
    if (delivered < 300) begin
      fails++;
      $display("FAIL throughput: got %0d delivered instructions, want >= 300", delivered);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
